// File: rtl/vending_machine.sv
// Wash programme sequencer: STARTED -> WASHING -> SPINNING -> DRYING -> FINISHED -> HALT,
// with each phase held for its own parameterised number of cycles.
module vending_machine #(
  parameter int START_CYCLES  = 1,
  parameter int WASH_CYCLES   = 4,
  parameter int SPIN_CYCLES   = 3,
  parameter int DRY_CYCLES    = 4,
  parameter int FINISH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] operation
);

  typedef enum logic [2:0] {
    S_STARTED  = 3'b000,
    S_WASHING  = 3'b001,
    S_SPINNING = 3'b010,
    S_DRYING   = 3'b011,
    S_FINISHED = 3'b100,
    S_HALT     = 3'b101
  } state_e;

  localparam int MAX_AB   = (START_CYCLES > WASH_CYCLES) ? START_CYCLES : WASH_CYCLES;
  localparam int MAX_CD   = (SPIN_CYCLES > DRY_CYCLES) ? SPIN_CYCLES : DRY_CYCLES;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_ALL  = (MAX_ABCD > FINISH_CYCLES) ? MAX_ABCD : FINISH_CYCLES;
  localparam int CNT_W    = $clog2(MAX_ALL) + 1;

  // Plain vector rather than the enum type so an upset can hold any 3-bit value.
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] last_count(input logic [2:0] s);
    case (s)
      S_STARTED:  return CNT_W'(START_CYCLES - 1);
      S_WASHING:  return CNT_W'(WASH_CYCLES - 1);
      S_SPINNING: return CNT_W'(SPIN_CYCLES - 1);
      S_DRYING:   return CNT_W'(DRY_CYCLES - 1);
      S_FINISHED: return CNT_W'(FINISH_CYCLES - 1);
      default:    return '0;
    endcase
  endfunction

  function automatic logic [2:0] next_phase(input logic [2:0] s);
    case (s)
      S_STARTED:  return S_WASHING;
      S_WASHING:  return S_SPINNING;
      S_SPINNING: return S_DRYING;
      S_DRYING:   return S_FINISHED;
      default:    return S_HALT;
    endcase
  endfunction

  // operation is loaded with the same value as state so it tracks the phase with no lag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_STARTED;
      operation <= S_STARTED;
      cnt       <= '0;
    end else begin
      case (state)
        S_STARTED, S_WASHING, S_SPINNING, S_DRYING, S_FINISHED: begin
          if (cnt == last_count(state)) begin
            state     <= next_phase(state);
            operation <= next_phase(state);
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HALT: begin
          operation <= S_HALT;
          cnt       <= '0;
        end
        default: begin
          state     <= S_HALT;
          operation <= S_HALT;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for the wash sequencer: stimulus queues expected codes, a negedge monitor compares.
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       rst_b;
  logic [2:0] op_a;
  logic [2:0] op_b;

  logic [2:0] qa[$];
  logic [2:0] qb[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vending_machine dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .operation (op_a)
  );

  vending_machine #(
    .WASH_CYCLES (1),
    .SPIN_CYCLES (1),
    .DRY_CYCLES  (1)
  ) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .operation (op_b)
  );

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [2:0] v, input int n);
    repeat (n) qa.push_back(v);
  endtask

  task automatic push_b(input logic [2:0] v, input int n);
    repeat (n) qb.push_back(v);
  endtask

  // Expected codes after edges 1..13 and a long HALT tail.
  task automatic push_full_a();
    push_a(3'b001, 4);
    push_a(3'b010, 3);
    push_a(3'b011, 4);
    push_a(3'b100, 1);
    push_a(3'b101, 30);
  endtask

  // Returns at negedge+1 once every queued expectation has been compared.
  task automatic drain();
    int budget = 0;
    while ((qa.size() != 0 || qb.size() != 0) && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d/%0d entries left, required 0", qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("op_a", op_a, e);
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("op_b", op_b, e);
      end
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("async_reset_a", op_a, 3'b000);
    check("async_reset_b", op_b, 3'b000);
    push_a(3'b000, 5);
    push_b(3'b000, 5);
    drain();

    // Full default sequence from reset release.
    rst_a = 1'b1;
    #1;
    check("release_a", op_a, 3'b000);
    push_full_a();
    drain();

    // Reset while parked in HALT, then the sequence restarts.
    rst_a = 1'b0;
    #1;
    check("async_reset_halt", op_a, 3'b000);
    push_a(3'b000, 2);
    drain();
    rst_a = 1'b1;
    push_full_a();
    drain();

    // Reset in the middle of WASHING, then full-length phases again.
    rst_a = 1'b0;
    push_a(3'b000, 1);
    drain();
    rst_a = 1'b1;
    push_a(3'b001, 2);
    drain();
    rst_a = 1'b0;
    #1;
    check("async_reset_wash", op_a, 3'b000);
    push_a(3'b000, 2);
    drain();
    rst_a = 1'b1;
    push_full_a();
    drain();

    // Illegal state upset recovers to HALT on the next edge.
    rst_a = 1'b0;
    push_a(3'b000, 1);
    drain();
    rst_a = 1'b1;
    push_a(3'b001, 1);
    drain();
    force dut_a.state = 3'b111;
    #1;
    release dut_a.state;
    push_a(3'b101, 4);
    drain();

    // Single-cycle phases step on consecutive edges.
    rst_b = 1'b1;
    #1;
    check("release_b", op_b, 3'b000);
    push_b(3'b001, 1);
    push_b(3'b010, 1);
    push_b(3'b011, 1);
    push_b(3'b100, 1);
    push_b(3'b101, 5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
